sw_job_ctrl: RTL and testbench

//  Job sequencer for the Smith-Waterman core (systolic array + S/T shifters).

---
 rtl/sw_job_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sw_job_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_job_ctrl.sv
// Smith-Waterman job sequencer: fetches S and T from the sequence SRAM, streams them
// into the systolic core with T-admission flow control, and returns the score with status.
module sw_job_ctrl #(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned NUM_PE  = 50,
    parameter int unsigned CLR_CYC = 2,
    parameter int unsigned TMO_W   = 20
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] s_base_i,
    input  logic [ADDR_W-1:0] t_base_i,
    input  logic [LEN_W-1:0]  s_len_i,
    input  logic [LEN_W-1:0]  t_len_i,
    output logic              ready_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              core_reset_o,
    output logic [2:0]        core_S_o,
    output logic [2:0]        core_T_o,
    output logic [LEN_W-1:0]  core_s_len_o,
    output logic [LEN_W-1:0]  core_t_len_o,
    input  logic              core_t_valid_in_i,
    input  logic              core_valid_i,
    input  logic [15:0]       core_max_i,
    output logic              done_o,
    output logic [15:0]       score_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        IDLE, CLR, LOAD_S, WAIT_T, LOAD_T, DRAIN, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] s_base_q, s_base_d, t_base_q, t_base_d;
    logic [LEN_W-1:0]  s_len_d, t_len_d;
    logic [LEN_W-1:0]  iss_q, iss_d, pres_q, pres_d, pres_inc;
    logic [TMO_W-1:0]  wd_q, wd_d, wd_inc;
    logic              rvalid_q;
    logic              rd_en;
    logic [15:0]       score_d;
    logic              err_d;
    logic              unused_rdata;

    assign unused_rdata = ^mem_rdata_i[7:3];
    assign pres_inc     = pres_q + LEN_W'(1);
    assign wd_inc       = wd_q + TMO_W'(1);

    // SRAM requests are gated by the live T-admission input, so no read issues while it is low
    assign mem_en_o   = rd_en;
    assign mem_addr_o = ((state_q == LOAD_T) ? t_base_q : s_base_q) + ADDR_W'(iss_q);
    assign core_S_o   = (state_q == LOAD_S && rvalid_q) ? mem_rdata_i[2:0] : 3'd0;
    assign core_T_o   = (state_q == LOAD_T && rvalid_q) ? mem_rdata_i[2:0] : 3'd0;

    // Next-state and datapath control; iss_q doubles as the CLR cycle counter
    always_comb begin
        state_d  = state_q;
        s_base_d = s_base_q;
        t_base_d = t_base_q;
        s_len_d  = core_s_len_o;
        t_len_d  = core_t_len_o;
        iss_d    = iss_q;
        pres_d   = pres_q;
        wd_d     = wd_q;
        score_d  = score_o;
        err_d    = err_o;
        rd_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    s_base_d = s_base_i;
                    t_base_d = t_base_i;
                    s_len_d  = s_len_i;
                    t_len_d  = t_len_i;
                    iss_d    = '0;
                    pres_d   = '0;
                    if (s_len_i > LEN_W'(NUM_PE)) begin
                        state_d = DONE;
                        score_d = '0;
                        err_d   = 1'b1;
                    end else if (s_len_i == '0 || t_len_i == '0) begin
                        state_d = DONE;
                        score_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = CLR;
                    end
                end
            end
            CLR: begin
                if (iss_q == LEN_W'(CLR_CYC - 1)) begin
                    state_d = LOAD_S;
                    iss_d   = '0;
                end else begin
                    iss_d = iss_q + LEN_W'(1);
                end
            end
            LOAD_S: begin
                rd_en = (iss_q < core_s_len_o);
                if (rd_en) iss_d = iss_q + LEN_W'(1);
                if (rvalid_q) begin
                    pres_d = pres_inc;
                    if (pres_inc == core_s_len_o) begin
                        state_d = WAIT_T;
                        iss_d   = '0;
                        pres_d  = '0;
                        wd_d    = '0;
                    end
                end
            end
            WAIT_T: begin
                if (core_t_valid_in_i) begin
                    state_d = LOAD_T;
                end else begin
                    wd_d = wd_inc;
                    if (&wd_inc) begin
                        state_d = DONE;
                        score_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD_T: begin
                rd_en = core_t_valid_in_i && (iss_q < core_t_len_o);
                if (rd_en) iss_d = iss_q + LEN_W'(1);
                if (!core_t_valid_in_i) wd_d = wd_inc;
                if (rvalid_q) pres_d = pres_inc;
                if (rvalid_q && pres_inc == core_t_len_o) begin
                    state_d = DRAIN;
                    wd_d    = '0;
                end else if (!core_t_valid_in_i && &wd_inc) begin
                    state_d = DONE;
                    score_d = '0;
                    err_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (core_valid_i) begin
                    state_d = DONE;
                    score_d = core_max_i;
                    err_d   = 1'b0;
                end else begin
                    wd_d = wd_inc;
                    if (&wd_inc) begin
                        state_d = DONE;
                        score_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            s_base_q     <= '0;
            t_base_q     <= '0;
            core_s_len_o <= '0;
            core_t_len_o <= '0;
            iss_q        <= '0;
            pres_q       <= '0;
            wd_q         <= '0;
            rvalid_q     <= 1'b0;
            ready_o      <= 1'b1;
            core_reset_o <= 1'b1;
            done_o       <= 1'b0;
            score_o      <= '0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_base_q     <= s_base_d;
            t_base_q     <= t_base_d;
            core_s_len_o <= s_len_d;
            core_t_len_o <= t_len_d;
            iss_q        <= iss_d;
            pres_q       <= pres_d;
            wd_q         <= wd_d;
            rvalid_q     <= rd_en;
            ready_o      <= (state_d == IDLE);
            core_reset_o <= (state_d == IDLE) || (state_d == CLR) || (state_d == DONE);
            done_o       <= (state_d == DONE);
            score_o      <= score_d;
            err_o        <= err_d;
        end
    end

endmodule

// File: tb/tb_sw_job_ctrl.sv
// Directed bench for sw_job_ctrl: SRAM model, simple core handshake driver, per-scenario checks.
module tb_sw_job_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [12:0] s_base_i = '0, t_base_i = '0;
    logic [15:0] s_len_i = '0, t_len_i = '0;
    logic        ready_o, mem_en_o, core_reset_o, done_o, err_o;
    logic [12:0] mem_addr_o;
    logic [7:0]  mem_rdata_i = '0;
    logic [2:0]  core_S_o, core_T_o;
    logic [15:0] core_s_len_o, core_t_len_o, score_o;
    logic        core_t_valid_in_i = 1'b1;
    logic        core_valid_i = 1'b0;
    logic [15:0] core_max_i = '0;

    int n_vec = 0;
    int n_err = 0;

    sw_job_ctrl #(.TMO_W(4)) dut (
        .clk(clk), .reset_i(reset_i), .start_i(start_i),
        .s_base_i(s_base_i), .t_base_i(t_base_i), .s_len_i(s_len_i), .t_len_i(t_len_i),
        .ready_o(ready_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .core_reset_o(core_reset_o),
        .core_S_o(core_S_o), .core_T_o(core_T_o),
        .core_s_len_o(core_s_len_o), .core_t_len_o(core_t_len_o),
        .core_t_valid_in_i(core_t_valid_in_i), .core_valid_i(core_valid_i),
        .core_max_i(core_max_i), .done_o(done_o), .score_o(score_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Sequence SRAM model: one-cycle read latency
    logic [7:0] mem [0:8191];
    always @(posedge clk) if (mem_en_o) mem_rdata_i <= mem[mem_addr_o];

    // Observation log, sampled on the falling edge
    int          cyc = 0;
    logic [31:0] s_pack, t_pack;
    int          s_num, t_num, s_first, s_last, last_t_cyc;
    logic [63:0] addr_log;
    int          rd_cnt, low_reads, t_low_sym, done_cnt, done_cyc;
    logic [15:0] done_score;
    logic        done_err;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (core_S_o != 3'd0) begin
            s_pack = {s_pack[27:0], 1'b0, core_S_o};
            if (s_num == 0) s_first = cyc;
            s_last = cyc;
            s_num  = s_num + 1;
        end
        if (core_T_o != 3'd0) begin
            t_pack = {t_pack[27:0], 1'b0, core_T_o};
            t_num  = t_num + 1;
            last_t_cyc = cyc;
            if (!core_t_valid_in_i) t_low_sym = t_low_sym + 1;
        end
        if (mem_en_o) begin
            if (rd_cnt < 4) addr_log = {addr_log[47:0], 3'b000, mem_addr_o};
            rd_cnt = rd_cnt + 1;
            if (!core_t_valid_in_i) low_reads = low_reads + 1;
        end
        if (done_o) begin
            done_cnt   = done_cnt + 1;
            done_cyc   = cyc;
            done_score = score_o;
            done_err   = err_o;
        end
    end

    int start_cyc;

    task automatic clear_mon();
        s_pack = '0; t_pack = '0; s_num = 0; t_num = 0; s_first = 0; s_last = 0;
        last_t_cyc = 0; addr_log = '0; rd_cnt = 0; low_reads = 0; t_low_sym = 0;
        done_cnt = 0; done_cyc = 0; done_score = '0; done_err = 1'b0;
    endtask

    // Launch one job and play the core: T-admission stall after a given T read, score after a delay
    task automatic run_job(input logic [12:0] sb, input logic [12:0] tb_, input logic [15:0] sl,
                           input logic [15:0] tl, input int stall_at, input int stall_len,
                           input int vdelay, input logic [15:0] mx, input int restart_at,
                           input int budget);
        int  stall_left = 0;
        bit  stalled = 1'b0;
        int  vcnt = -1;
        bit  vsent = 1'b0;
        clear_mon();
        @(posedge clk); #1;
        s_base_i = sb; t_base_i = tb_; s_len_i = sl; t_len_i = tl; start_i = 1'b1;
        @(posedge clk);
        start_cyc = cyc;
        #1 start_i = 1'b0;
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            if (stall_at > 0 && !stalled && rd_cnt == int'(sl) + stall_at) begin
                stalled = 1'b1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                core_t_valid_in_i = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                core_t_valid_in_i = 1'b1;
            end
            core_valid_i = 1'b0;
            if (vdelay >= 0 && !vsent && t_num == int'(tl)) begin
                if (vcnt < 0) vcnt = vdelay;
                if (vcnt == 0) begin
                    core_valid_i = 1'b1;
                    core_max_i = mx;
                    vsent = 1'b1;
                end else begin
                    vcnt = vcnt - 1;
                end
            end
            start_i = (i == restart_at);
            if (i == restart_at) begin
                s_len_i = '0;
                t_len_i = '0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        core_valid_i = 1'b0;
        core_t_valid_in_i = 1'b1;
        n_vec++;
        if (done_cnt == 0) begin
            n_err++;
            $display("FAIL job_timeout: done_o seen %0d times, required at least 1", done_cnt);
        end
    endtask

    task automatic test_reset();
        logic [71:0] obs;
        #3 reset_i = 1'b0;
        @(negedge clk);
        obs = {ready_o, core_reset_o, mem_en_o, mem_addr_o, core_S_o, core_T_o,
               core_s_len_o, core_t_len_o, done_o, score_o, err_o};
        n_vec++;
        if (obs !== {2'b11, 70'd0}) begin
            n_err++;
            $display("FAIL reset_values: got %h required %h", obs, {2'b11, 70'd0});
        end
        @(posedge clk); #1 reset_i = 1'b1;
        repeat (2) @(negedge clk);
        obs = {ready_o, core_reset_o, mem_en_o, mem_addr_o, core_S_o, core_T_o,
               core_s_len_o, core_t_len_o, done_o, score_o, err_o};
        n_vec++;
        if (obs !== {2'b11, 70'd0}) begin
            n_err++;
            $display("FAIL idle_after_reset: got %h required %h", obs, {2'b11, 70'd0});
        end
    endtask

    task automatic test_basic_job();
        run_job(13'd0, 13'd16, 16'd3, 16'd4, 0, 0, 2, 16'd7, -1, 200);
        n_vec++;
        if (s_pack !== 32'h123 || s_num != 3) begin
            n_err++; $display("FAIL basic_s_seq: got %h/%0d required 123/3", s_pack, s_num);
        end
        n_vec++;
        if (s_last - s_first != 2) begin
            n_err++; $display("FAIL basic_s_consecutive: got span %0d required 2", s_last - s_first);
        end
        n_vec++;
        if (t_pack !== 32'h4123 || t_num != 4) begin
            n_err++; $display("FAIL basic_t_seq: got %h/%0d required 4123/4", t_pack, t_num);
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_err++; $display("FAIL basic_done_count: got %0d required 1", done_cnt);
        end
        n_vec++;
        if (done_score !== 16'd7 || done_err !== 1'b0) begin
            n_err++; $display("FAIL basic_result: got score %0d err %b required 7 0", done_score, done_err);
        end
        n_vec++;
        if (done_o !== 1'b0 || ready_o !== 1'b1 || score_o !== 16'd7) begin
            n_err++;
            $display("FAIL basic_after_done: got done %b ready %b score %0d required 0 1 7",
                     done_o, ready_o, score_o);
        end
    endtask

    task automatic test_t_stall();
        run_job(13'd0, 13'd16, 16'd3, 16'd4, 2, 3, 2, 16'hBEEF, -1, 200);
        n_vec++;
        if (t_pack !== 32'h4123 || t_num != 4) begin
            n_err++; $display("FAIL stall_t_seq: got %h/%0d required 4123/4", t_pack, t_num);
        end
        n_vec++;
        if (t_low_sym != 1) begin
            n_err++; $display("FAIL stall_inflight: got %0d symbols while low, required 1", t_low_sym);
        end
        n_vec++;
        if (low_reads != 0) begin
            n_err++; $display("FAIL stall_reads_low: got %0d reads while low, required 0", low_reads);
        end
        n_vec++;
        if (done_score !== 16'hBEEF || done_err !== 1'b0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL stall_result: got score %h err %b done %0d required beef 0 1",
                     done_score, done_err, done_cnt);
        end
    endtask

    task automatic test_bad_len();
        run_job(13'd0, 13'd16, 16'd51, 16'd4, 0, 0, -1, 16'd0, -1, 20);
        n_vec++;
        if (done_cyc != start_cyc + 1) begin
            n_err++; $display("FAIL long_s_latency: got %0d cycles required 1", done_cyc - start_cyc);
        end
        n_vec++;
        if (done_err !== 1'b1 || done_score !== 16'd0) begin
            n_err++; $display("FAIL long_s_result: got err %b score %0d required 1 0", done_err, done_score);
        end
        n_vec++;
        if (rd_cnt != 0) begin
            n_err++; $display("FAIL long_s_no_reads: got %0d reads required 0", rd_cnt);
        end
        run_job(13'd0, 13'd16, 16'd0, 16'd4, 0, 0, -1, 16'd0, -1, 20);
        n_vec++;
        if (done_err !== 1'b0 || done_score !== 16'd0 || done_cnt != 1 || rd_cnt != 0) begin
            n_err++;
            $display("FAIL zero_s_result: got err %b score %0d done %0d reads %0d required 0 0 1 0",
                     done_err, done_score, done_cnt, rd_cnt);
        end
        run_job(13'd0, 13'd16, 16'd2, 16'd0, 0, 0, -1, 16'd0, -1, 20);
        n_vec++;
        if (done_err !== 1'b0 || done_score !== 16'd0 || rd_cnt != 0) begin
            n_err++;
            $display("FAIL zero_t_result: got err %b score %0d reads %0d required 0 0 0",
                     done_err, done_score, rd_cnt);
        end
    endtask

    task automatic test_addr_wrap();
        run_job(13'd8190, 13'd100, 16'd4, 16'd2, 0, 0, 1, 16'd3, -1, 200);
        n_vec++;
        if (addr_log !== 64'h1FFE_1FFF_0000_0001) begin
            n_err++; $display("FAIL wrap_addr: got %h required 1ffe1fff00000001", addr_log);
        end
        n_vec++;
        if (s_pack !== 32'h5612 || t_pack !== 32'h56 || done_score !== 16'd3) begin
            n_err++;
            $display("FAIL wrap_data: got S %h T %h score %0d required 5612 56 3",
                     s_pack, t_pack, done_score);
        end
    endtask

    task automatic test_watchdog();
        run_job(13'd0, 13'd16, 16'd3, 16'd4, 0, 0, -1, 16'd0, -1, 200);
        n_vec++;
        if (done_cyc - last_t_cyc != 16) begin
            n_err++;
            $display("FAIL wdog_drain_len: got %0d drain cycles required 15", done_cyc - last_t_cyc - 1);
        end
        n_vec++;
        if (done_err !== 1'b1 || done_score !== 16'd0) begin
            n_err++; $display("FAIL wdog_result: got err %b score %0d required 1 0", done_err, done_score);
        end
        n_vec++;
        if (ready_o !== 1'b1 || done_o !== 1'b0) begin
            n_err++; $display("FAIL wdog_ready: got ready %b done %b required 1 0", ready_o, done_o);
        end
    endtask

    task automatic test_reset_mid_job();
        logic [71:0] obs;
        clear_mon();
        @(posedge clk); #1;
        s_base_i = 13'd0; t_base_i = 13'd16; s_len_i = 16'd3; t_len_i = 16'd4; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        for (int i = 0; i < 50 && rd_cnt < 4; i++) @(posedge clk);
        n_vec++;
        if (rd_cnt < 4) begin
            n_err++; $display("FAIL midrst_reach_load_t: got %0d reads required 4", rd_cnt);
        end
        #3 reset_i = 1'b0;
        #1;
        obs = {ready_o, core_reset_o, mem_en_o, mem_addr_o, core_S_o, core_T_o,
               core_s_len_o, core_t_len_o, done_o, score_o, err_o};
        n_vec++;
        if (obs !== {2'b11, 70'd0}) begin
            n_err++; $display("FAIL midrst_values: got %h required %h", obs, {2'b11, 70'd0});
        end
        @(posedge clk); #1 reset_i = 1'b1;
        run_job(13'd0, 13'd16, 16'd3, 16'd4, 0, 0, 2, 16'd9, 3, 200);
        n_vec++;
        if (done_cnt != 1 || s_pack !== 32'h123 || t_pack !== 32'h4123) begin
            n_err++;
            $display("FAIL midrst_rerun_seq: got done %0d S %h T %h required 1 123 4123",
                     done_cnt, s_pack, t_pack);
        end
        n_vec++;
        if (done_score !== 16'd9 || done_err !== 1'b0) begin
            n_err++; $display("FAIL midrst_rerun_result: got score %0d err %b required 9 0", done_score, done_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h01;
        mem[0]  = 8'hA9; mem[1]  = 8'h02; mem[2]  = 8'hFB;
        mem[16] = 8'h24; mem[17] = 8'hF9; mem[18] = 8'h0A; mem[19] = 8'h13;
        mem[100] = 8'h0D; mem[101] = 8'h16;
        mem[8190] = 8'h35; mem[8191] = 8'hCE;
        clear_mon();
        test_reset();
        test_basic_job();
        test_t_stall();
        test_bad_len();
        test_addr_wrap();
        test_watchdog();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
